// File: rtl/grid_color_ctrl.sv
// grid_color_ctrl: 4x4 board colour store with cursor, paint, clear sequence and cursor blink.
// dirColor is a pure combinational lookup so the VGA scan sees the store with no latency.
module grid_color_ctrl #(
    parameter int             AW            = 4,
    parameter int             DW            = 3,
    parameter logic [DW-1:0]  DEFAULT_COLOR = 3'b000,
    parameter int             BLINK_FRAMES  = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_paint,
    input  logic          btn_clear,
    input  logic [DW-1:0] color_sel,
    input  logic [AW-1:0] posicion,
    output logic [DW-1:0] dirColor,
    output logic [AW-1:0] cursor,
    output logic          busy
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [5:0] BLINK_MAX = 6'(BLINK_FRAMES - 1);

    logic [DW-1:0] r_cells [16];
    logic [1:0]    r_col, r_row;
    logic [5:0]    r_prev;
    state_t        r_state;
    logic          r_busy;
    logic [AW-1:0] r_clr_addr;
    logic [5:0]    r_blink_cnt;
    logic          r_blink_on;

    logic [5:0]    w_btn, w_ev;
    state_t        w_state_nxt;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [1:0]    w_col_nxt, w_row_nxt;
    logic [AW-1:0] w_clr_nxt;
    logic [AW-1:0] w_cursor;
    logic [DW-1:0] w_cell;

    assign w_btn    = {btn_up, btn_down, btn_left, btn_right, btn_paint, btn_clear};
    assign w_ev     = w_btn & ~r_prev;
    // index = 15 - 4*col - row is just the bitwise inverse of {col,row}
    assign w_cursor = ~{r_col, r_row};
    assign cursor   = w_cursor;
    assign busy     = r_busy;
    assign w_cell   = r_cells[posicion];
    assign dirColor = (r_blink_on && posicion == w_cursor) ? ~w_cell : w_cell;

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_waddr     = w_cursor;
        w_wdata     = color_sel;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_clr_nxt   = r_clr_addr;
        if (r_state == IDLE) begin
            if (w_ev[0]) begin
                w_state_nxt = CLEAR;
                w_clr_nxt   = '0;
            end else if (w_ev[1]) begin
                w_we = 1'b1;
            end else if (w_ev[5]) begin
                w_row_nxt = r_row - 2'd1;
            end else if (w_ev[4]) begin
                w_row_nxt = r_row + 2'd1;
            end else if (w_ev[3]) begin
                w_col_nxt = r_col - 2'd1;
            end else if (w_ev[2]) begin
                w_col_nxt = r_col + 2'd1;
            end
        end else begin
            w_we        = 1'b1;
            w_waddr     = r_clr_addr;
            w_wdata     = DEFAULT_COLOR;
            w_clr_nxt   = r_clr_addr + 1'b1;
            w_state_nxt = (r_clr_addr == '1) ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) r_cells[i] <= DEFAULT_COLOR;
            r_col       <= '0;
            r_row       <= '0;
            r_prev      <= '0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_clr_addr  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            if (w_we) r_cells[w_waddr] <= w_wdata;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_prev     <= w_btn;
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == CLEAR);
            r_clr_addr <= w_clr_nxt;
            if (frame_tick) begin
                if (r_blink_cnt == BLINK_MAX) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 6'd1;
                end
            end
        end
    end
endmodule
